// File: rtl/pacman_mover.sv
// Pac-Man movement controller: probes a requested turn and the current heading
// against the collision checker, then steps the position once per tick.
module pacman_mover #(
  parameter logic [8:0] START_X = 9'd168,
  parameter logic [8:0] START_Y = 9'd232,
  parameter logic [8:0] STEP    = 9'd1,
  parameter int         SETTLE  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] dir_req,
  input  logic       collide,
  output logic [3:0] direction,
  output logic [8:0] p_x,
  output logic [8:0] p_y,
  output logic [3:0] cur_dir,
  output logic       moving,
  output logic       done
);

  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  localparam logic [3:0] D_LEFT  = 4'b1000;
  localparam logic [3:0] D_UP    = 4'b0100;
  localparam logic [3:0] D_RIGHT = 4'b0010;
  localparam logic [3:0] D_DOWN  = 4'b0001;

  typedef enum logic [1:0] {
    IDLE,
    PROBE_REQ,
    PROBE_CUR,
    MOVE
  } state_t;

  state_t        state;
  logic [3:0]    req_q;
  logic [CW-1:0] cnt;
  logic          mv_q;
  logic          req_turn;

  // A request only counts as a turn if it is one-hot and a new heading
  always_comb begin
    req_turn = 1'b0;
    if (dir_req != 4'b0000 &&
        (dir_req & (dir_req - 4'd1)) == 4'b0000 &&
        dir_req != cur_dir)
      req_turn = 1'b1;
  end

  // Evaluation FSM; all outputs are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      p_x       <= START_X;
      p_y       <= START_Y;
      cur_dir   <= D_LEFT;
      direction <= D_LEFT;
      moving    <= 1'b0;
      done      <= 1'b0;
      req_q     <= 4'b0000;
      cnt       <= '0;
      mv_q      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (tick) begin
            req_q <= dir_req;
            if (req_turn) begin
              direction <= dir_req;
              state     <= PROBE_REQ;
            end else begin
              direction <= cur_dir;
              state     <= PROBE_CUR;
            end
          end
        end
        PROBE_REQ: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= PROBE_CUR;
            if (!collide) begin
              cur_dir   <= req_q;
              direction <= req_q;
            end else begin
              direction <= cur_dir;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PROBE_CUR: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            mv_q  <= ~collide;
            state <= MOVE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        MOVE: begin
          if (mv_q) begin
            unique case (1'b1)
              cur_dir[3]: p_x <= p_x - STEP;
              cur_dir[2]: p_y <= p_y - STEP;
              cur_dir[1]: p_x <= p_x + STEP;
              cur_dir[0]: p_y <= p_y + STEP;
              default: ;
            endcase
          end
          moving    <= mv_q;
          done      <= 1'b1;
          direction <= cur_dir;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pacman_mover.sv
// Directed bench for pacman_mover.
// Edges are counted from the tick-sampling edge E0.
module tb_pacman_mover;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] dir_req;
  logic       collide;
  logic [3:0] direction;
  logic [8:0] p_x;
  logic [8:0] p_y;
  logic [3:0] cur_dir;
  logic       moving;
  logic       done;

  int checks = 0;
  int errors = 0;

  pacman_mover dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .dir_req(dir_req),
    .collide(collide),
    .direction(direction),
    .p_x(p_x),
    .p_y(p_y),
    .cur_dir(cur_dir),
    .moving(moving),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick = 1'b0;
    dir_req = 4'b0000;
    collide = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (p_x !== 9'd168 || p_y !== 9'd232) begin
      errors++;
      $display("FAIL reset_pos: got (%0d,%0d) want (168,232)", p_x, p_y);
    end
    checks++;
    if (cur_dir !== 4'b1000 || direction !== 4'b1000) begin
      errors++;
      $display("FAIL reset_dir: got cur=%b dir=%b want 1000/1000",
               cur_dir, direction);
    end
    checks++;
    if (done !== 1'b0 || moving !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got done=%b moving=%b want 0/0",
               done, moving);
    end
  endtask

  task automatic test_move_left();
    dir_req = 4'b1000;
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step();
      checks++;
      if (p_x !== 9'd168 || done !== 1'b0) begin
        errors++;
        $display("FAIL left_early E%0d: got x=%0d done=%b want 168/0",
                 e, p_x, done);
      end
    end
    step();
    checks++;
    if (p_x !== 9'd167 || p_y !== 9'd232 || done !== 1'b1 || moving !== 1'b1) begin
      errors++;
      $display("FAIL left_E4: got (%0d,%0d) done=%b mv=%b want (167,232) 1 1",
               p_x, p_y, done, moving);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL left_done_pulse: got done=%b want 0", done);
    end
  endtask

  task automatic test_turn_up();
    dir_req = 4'b0100;
    tick = 1'b1;
    step();
    tick = 1'b0;
    dir_req = 4'b0001;
    for (int e = 0; e <= 6; e++) begin
      if (e > 0) step();
      checks++;
      if (direction !== 4'b0100) begin
        errors++;
        $display("FAIL up_direction E%0d: got %b want 0100", e, direction);
      end
      if (e == 2) begin
        checks++;
        if (cur_dir !== 4'b1000) begin
          errors++;
          $display("FAIL up_curdir_E2: got %b want 1000", cur_dir);
        end
      end
      if (e == 3) begin
        checks++;
        if (cur_dir !== 4'b0100) begin
          errors++;
          $display("FAIL up_curdir_E3: got %b want 0100", cur_dir);
        end
      end
      if (e == 6) begin
        checks++;
        if (p_y !== 9'd232 || done !== 1'b0) begin
          errors++;
          $display("FAIL up_E6: got y=%0d done=%b want 232/0", p_y, done);
        end
      end
    end
    step();
    checks++;
    if (p_y !== 9'd231 || p_x !== 9'd167 || done !== 1'b1) begin
      errors++;
      $display("FAIL up_E7: got (%0d,%0d) done=%b want (167,231) 1",
               p_x, p_y, done);
    end
    step();
  endtask

  task automatic test_blocked_turn();
    dir_req = 4'b1000;
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int e = 1; e <= 8; e++) step();
    checks++;
    if (cur_dir !== 4'b1000 || p_x !== 9'd166 || p_y !== 9'd231) begin
      errors++;
      $display("FAIL back_left: got cur=%b (%0d,%0d) want 1000 (166,231)",
               cur_dir, p_x, p_y);
    end
    dir_req = 4'b0010;
    collide = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
    step();
    collide = 1'b0;
    checks++;
    if (cur_dir !== 4'b1000 || direction !== 4'b1000) begin
      errors++;
      $display("FAIL blocked_curdir: got cur=%b dir=%b want 1000/1000",
               cur_dir, direction);
    end
    step();
    step();
    step();
    checks++;
    if (p_x !== 9'd166) begin
      errors++;
      $display("FAIL blocked_E6: got x=%0d want 166", p_x);
    end
    step();
    checks++;
    if (p_x !== 9'd165 || done !== 1'b1 || moving !== 1'b1) begin
      errors++;
      $display("FAIL blocked_E7: got x=%0d done=%b mv=%b want 165 1 1",
               p_x, done, moving);
    end
    step();
  endtask

  task automatic test_no_request();
    collide = 1'b1;
    dir_req = 4'b0000;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
    step();
    step();
    checks++;
    if (p_x !== 9'd165 || p_y !== 9'd231 || moving !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL noreq_E4: got (%0d,%0d) mv=%b done=%b want (165,231) 0 1",
               p_x, p_y, moving, done);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL noreq_done_pulse: got %b want 0", done);
    end
    collide = 1'b0;
  endtask

  task automatic test_not_onehot();
    dir_req = 4'b1100;
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int e = 1; e <= 4; e++) step();
    checks++;
    if (p_x !== 9'd164 || cur_dir !== 4'b1000 || done !== 1'b1) begin
      errors++;
      $display("FAIL not_onehot: got x=%0d cur=%b done=%b want 164 1000 1",
               p_x, cur_dir, done);
    end
    step();
  endtask

  task automatic test_wrap();
    int dones;
    do_reset();
    dir_req = 4'b1000;
    for (int i = 0; i < 168; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      for (int e = 1; e <= 4; e++) step();
    end
    checks++;
    if (p_x !== 9'd0) begin
      errors++;
      $display("FAIL wrap_reach_zero: got x=%0d want 0", p_x);
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    step();
    checks++;
    if (p_x !== 9'd511 || done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_E4: got x=%0d done=%b want 511 1", p_x, done);
    end
    dones = 0;
    for (int e = 0; e < 12; e++) begin
      step();
      if (done === 1'b1) dones++;
    end
    checks++;
    if (p_x !== 9'd511 || dones !== 0) begin
      errors++;
      $display("FAIL wrap_single_update: got x=%0d dones=%0d want 511 0",
               p_x, dones);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    dir_req = 4'b0100;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (p_x !== 9'd168 || p_y !== 9'd232 || cur_dir !== 4'b1000 ||
        direction !== 4'b1000 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: got (%0d,%0d) cur=%b dir=%b done=%b",
               p_x, p_y, cur_dir, direction, done);
    end
    dones = 0;
    for (int e = 0; e < 10; e++) begin
      step();
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0 || p_x !== 9'd168 || p_y !== 9'd232 || cur_dir !== 4'b1000) begin
      errors++;
      $display("FAIL abort_idle: got dones=%0d (%0d,%0d) cur=%b want 0 (168,232) 1000",
               dones, p_x, p_y, cur_dir);
    end
  endtask

  initial begin
    test_reset();
    test_move_left();
    test_turn_up();
    test_blocked_turn();
    test_no_request();
    test_not_onehot();
    test_wrap();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
